load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 17 +
 rtl/lsu_align.sv | 23 ++
 rtl/load_store_unit.sv | 91 +++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, size encodings and fault rules for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {IDLE, RD, RDWAIT, WR, RESP} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam int MEM_WORDS  = 32;
  localparam int WORD_IDX_W = 5;
  function automatic logic lsu_fault(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] a);
    return (ld == st) || |a[31:7] ||
           !((f3 inside {F3_B, F3_H, F3_W}) || (ld && (f3 inside {F3_BU, F3_HU}))) ||
           ((f3 == F3_H || f3 == F3_HU) && a[0]) || (f3 == F3_W && |a[1:0]);
  endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: little-endian load extract/extend and byte/halfword store merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [4:0]  sh;
  logic [31:0] s, mask;
  assign sh = {offset, 3'b000};
  assign s = word >> sh;
  assign load_data = funct3 == F3_B  ? {{24{s[7]}}, s[7:0]} :
                     funct3 == F3_BU ? {24'b0, s[7:0]} :
                     funct3 == F3_H  ? {{16{s[15]}}, s[15:0]} :
                     funct3 == F3_HU ? {16'b0, s[15:0]} : word;
  assign mask = funct3 == F3_B ? 32'h0000_00ff << sh :
                funct3 == F3_H ? 32'h0000_ffff << sh : '1;
  assign merged = (word & ~mask) | ((wdata << sh) & mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store FSM with read-modify-write for sub-word stores
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_result,
  output logic        resp_valid,
  output logic        resp_rd_write,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_fault
);
  state_t      state, state_d;
  logic        is_load, accept, req_fault;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [4:0]  rd;
  logic [31:0] wdata, load_data, merged;
  // ready is a decode of the state flop, gated so it drops the instant reset asserts
  assign req_ready = reset && state == IDLE;
  assign accept = req_valid && req_ready;
  assign req_fault = lsu_fault(req_load, req_store, req_funct3, req_address);
  lsu_align u_align (
    .funct3   (f3),
    .offset   (off),
    .word     (mem_result),
    .wdata    (wdata),
    .load_data(load_data),
    .merged   (merged)
  );
  always_comb begin
    state_d = state == IDLE   ? (!accept ? IDLE : req_fault ? RESP :
                                 (req_store && req_funct3 == F3_W) ? WR : RD) :
              state == RD     ? RDWAIT :
              state == RDWAIT ? (is_load ? RESP : WR) :
              state == WR     ? RESP : IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_d;
  // outputs are registered from the next-state decode so they line up with the state
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      is_load        <= 1'b0;
      f3             <= '0;
      off            <= '0;
      rd             <= '0;
      wdata          <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_rd_write  <= 1'b0;
      resp_rd        <= '0;
      resp_data      <= '0;
      resp_fault     <= 1'b0;
    end else begin
      if (accept) begin
        is_load     <= req_load;
        f3          <= req_funct3;
        off         <= req_address[1:0];
        rd          <= req_rd;
        wdata       <= req_wdata;
        mem_address <= {{(32-WORD_IDX_W){1'b0}}, req_address[WORD_IDX_W+1:2]};
      end
      mem_read  <= state_d == RD;
      mem_write <= state_d == WR;
      if (state_d == WR) mem_write_data <= state == IDLE ? req_wdata : merged;
      resp_valid    <= state_d == RESP;
      resp_fault    <= state_d == RESP && state == IDLE;
      resp_rd_write <= state_d == RESP && state == RDWAIT && is_load && rd != '0;
      if (state_d == RESP) begin
        resp_rd   <= state == IDLE ? req_rd : rd;
        resp_data <= (state == RDWAIT && is_load) ? load_data : '0;
      end
    end
endmodule
